bcd_serial_alu: RTL and testbench
=================================

# bcd_serial_alu

Parametrised, digit-serial packed-BCD adder/subtractor with signed-magnitude result and per-digit seven-segment drive. It is the sequential successor to the board-level two-digit BCD add/subtract datapath and sits between the switch/operand capture logic and the HEX display bank. It is generalised to DIGITS digits and handles subtraction correctly for a negative result, reporting sign and magnitude. It also flags add overflow and non-BCD operands.

## Interface
- DIGITS, 4, number of BCD digits per operand and result (≥1)
- CLOCK_50  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = A+B, 1 = A−B; captured with start
- a_bcd  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]; captured with start
- b_bcd  in  4*DIGITS  operand B, same packing
- busy  out  1  high in CALC and NEG
- done  out  1  one-cycle pulse in DONE
- result  out  4*DIGITS  magnitude, packed BCD, held until next DONE
- sign  out  1  1 = result negative (subtract only)
- ovf  out  1  add carry out of the top digit
- err  out  1  an input digit was >9
- seg  out  7*DIGITS  active-low segments, digit i at [7i+6:7i], bit order a..g = [7i+6]..[7i]

## Operation
- FSM states: IDLE, CALC, NEG, DONE.
- IDLE: when start=1, capture a_bcd, b_bcd and op into working registers; clear digit index and set carry = op. If any nibble of a_bcd or b_bcd exceeds 9, go to DONE with err pending. Otherwise go to CALC.
- CALC: one digit per cycle, LSD first, index 0..DIGITS−1.
  - b' = b_i (add) or 9−b_i (sub); t = a_i + b' + carry, computed 5 bits wide (max 19).
  - If t>9: digit = t−10, carry = 1. Else: digit = t, carry = 0.
- After the last digit:
  - Add → DONE, ovf = final carry.
  - Sub with final carry=1 → DONE, sign = 0.
  - Sub with final carry=0 → NEG.
- NEG: DIGITS cycles, LSD first, with carry initialised to 1. Each digit becomes (9−r_i) + carry with the same >9 correction (ten's complement, i.e. magnitude). The carry out is discarded; sign = 1.
- DONE: result, sign, ovf and err load from the working state in one register update; done=1 for this one cycle; next state IDLE.
- err case: result = 0, sign = 0, ovf = 0, and every seg digit is blank (all 1s).
- sign and ovf are 0 whenever not applicable; ovf is never set for subtraction.
- start outside IDLE, including in DONE, is ignored and not queued.
- Operand inputs may change freely after the capture cycle.
- seg is combinational from the registered result/err. Encoding:
  - 0: a b c d e f
  - 1: b c
  - 2: a b d e g
  - 3: a b c d g
  - 4: b c f g
  - 5: a c d f g
  - 6: a c d e f g
  - 7: a b c
  - 8: all
  - 9: a b c f g

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; busy 0, done 0, result 0, sign 0, ovf 0, err 0; seg shows "0" on every digit.
- Reset asserted in CALC or NEG aborts the operation with no done pulse; registered outputs return to reset values.
- Cycle 0 is the cycle in which start=1 is seen in IDLE.
- Add, or subtract with non-negative result: CALC in cycles 1..DIGITS, done in cycle DIGITS+1.
- Subtract with negative result: NEG in cycles DIGITS+1..2·DIGITS, done in cycle 2·DIGITS+1.
- Invalid operand: done in cycle 1; busy never asserts.
- Earliest next accepted start is the cycle after done.
- result, sign, ovf, err and seg change only at the edge entering DONE (and on reset). They are stable from the done cycle until the next DONE.

## Test plan
- Add, DIGITS=4: A=1234, B=5678, op=0 → done at cycle 5, result 6912, sign 0, ovf 0; seg digit 3 shows 6 (0100000).
- Add overflow: 9999 + 0001 → result 0000, ovf 1, done at cycle 5.
- Subtract, non-negative: 1000 − 0001 → result 0999, sign 0, done at cycle 5. Also 0500 − 0500 → 0000, sign 0.
- Subtract, negative: 0001 − 1000 → result 0999, sign 1, done at cycle 9, busy high in cycles 1–8.
- Invalid operand: A=12A4 → done at cycle 1, err 1, result 0000, all seg bits 1. A following valid op clears err.
- Control: start pulsed during busy is ignored. RESET_N low at cycle 3 of a subtract gives no done pulse, outputs at reset values, and a new start is accepted after release. Also sweep DIGITS=1 and DIGITS=8 against a reference model with random valid operands.

Source files
------------

// File: rtl/bcd_serial_alu.sv
// rtl/bcd_serial_alu.sv - digit-serial packed-BCD add/subtract with sign-magnitude result and seven-segment drive
module bcd_serial_alu #(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  sign,
    output logic                  ovf,
    output logic                  err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q,  state_d;
    logic [IW-1:0]       idx_q,    idx_d;
    logic                carry_q,  carry_d;
    logic                op_q,     op_d;
    logic [4*DIGITS-1:0] a_q,      a_d;
    logic [4*DIGITS-1:0] b_q,      b_d;
    logic [4*DIGITS-1:0] w_q,      w_d;
    logic [4*DIGITS-1:0] result_q, result_d;
    logic                sign_q,   sign_d;
    logic                ovf_q,    ovf_d;
    logic                err_q,    err_d;

    logic [3:0] a_dig, b_dig, w_dig, x_dig, y_dig, dig;
    logic [4:0] t;
    logic       cout;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Active-low segment pattern, bit 6 = a ... bit 0 = g
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One decimal digit step: CALC adds a_i to b_i or its nines complement,
    // NEG nines-complements the working digit and adds the incoming carry.
    always_comb begin
        a_dig = a_q[{idx_q, 2'b00} +: 4];
        b_dig = b_q[{idx_q, 2'b00} +: 4];
        w_dig = w_q[{idx_q, 2'b00} +: 4];
        if (state_q == S_NEG) begin
            x_dig = 4'd9 - w_dig;
            y_dig = 4'd0;
        end else begin
            x_dig = a_dig;
            y_dig = op_q ? (4'd9 - b_dig) : b_dig;
        end
        t = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0000, carry_q};
        if (t > 5'd9) begin
            // t is 10..19 here, so the low nibble minus ten wraps to t-10
            dig  = t[3:0] - 4'd10;
            cout = 1'b1;
        end else begin
            dig  = t[3:0];
            cout = 1'b0;
        end
    end

    // Control FSM and working datapath; visible outputs only load on entry to DONE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        w_d      = w_q;
        result_d = result_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_bcd;
                    b_d     = b_bcd;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = op;
                    w_d     = '0;
                    if (has_bad_digit(a_bcd) || has_bad_digit(b_bcd)) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        sign_d   = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_d[{idx_q, 2'b00} +: 4] = dig;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (!op_q || cout) begin
                        // Add, or subtract whose ten's-complement sum carried out (A >= B)
                        state_d  = S_DONE;
                        result_d = w_d;
                        sign_d   = 1'b0;
                        ovf_d    = !op_q && cout;
                        err_d    = 1'b0;
                    end else begin
                        state_d = S_NEG;
                        carry_d = 1'b1;
                    end
                end
            end
            S_NEG: begin
                w_d[{idx_q, 2'b00} +: 4] = dig;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    state_d  = S_DONE;
                    result_d = w_d;
                    sign_d   = 1'b1;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            w_q      <= w_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Seven-segment drive from the registered result; blank on operand error
    always_comb begin
        seg = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = err_q ? 7'b1111111 : seg_enc(result_q[4*i +: 4]);
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_NEG);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign sign   = sign_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb/tb_bcd_serial_alu.sv - randomized self-checking bench for bcd_serial_alu at 4, 1 and 8 digits
module tb_bcd_serial_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op;
    logic [31:0] a_bus, b_bus;
    logic        start4, start1, start8;

    always #5 clk = ~clk;

    logic        busy4, done4, sign4, ovf4, err4;
    logic [15:0] res4;
    logic [27:0] seg4;
    logic        busy1, done1, sign1, ovf1, err1;
    logic [3:0]  res1;
    logic [6:0]  seg1;
    logic        busy8, done8, sign8, ovf8, err8;
    logic [31:0] res8;
    logic [55:0] seg8;

    bcd_serial_alu #(.DIGITS(4)) u_d4 (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start4), .op(op),
        .a_bcd(a_bus[15:0]), .b_bcd(b_bus[15:0]),
        .busy(busy4), .done(done4), .result(res4), .sign(sign4),
        .ovf(ovf4), .err(err4), .seg(seg4)
    );

    bcd_serial_alu #(.DIGITS(1)) u_d1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start1), .op(op),
        .a_bcd(a_bus[3:0]), .b_bcd(b_bus[3:0]),
        .busy(busy1), .done(done1), .result(res1), .sign(sign1),
        .ovf(ovf1), .err(err1), .seg(seg1)
    );

    bcd_serial_alu #(.DIGITS(8)) u_d8 (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start8), .op(op),
        .a_bcd(a_bus), .b_bcd(b_bus),
        .busy(busy8), .done(done8), .result(res8), .sign(sign8),
        .ovf(ovf8), .err(err8), .seg(seg8)
    );

    int          sel;
    logic        cur_busy, cur_done, cur_sign, cur_ovf, cur_err;
    logic [31:0] cur_res;
    logic [55:0] cur_seg;

    always_comb begin
        cur_busy = busy4; cur_done = done4; cur_sign = sign4; cur_ovf = ovf4; cur_err = err4;
        cur_res  = {16'h0, res4};
        cur_seg  = {28'h0, seg4};
        if (sel == 1) begin
            cur_busy = busy1; cur_done = done1; cur_sign = sign1; cur_ovf = ovf1; cur_err = err1;
            cur_res  = {28'h0, res1};
            cur_seg  = {49'h0, seg1};
        end else if (sel == 2) begin
            cur_busy = busy8; cur_done = done8; cur_sign = sign8; cur_ovf = ovf8; cur_err = err8;
            cur_res  = res8;
            cur_seg  = seg8;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_res [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ndig(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    function automatic longint bcd2int(input logic [31:0] v, input int n);
        longint x = 0;
        for (int i = n - 1; i >= 0; i--) x = x * 10 + longint'(v[4*i +: 4]);
        return x;
    endfunction

    function automatic logic [31:0] int2bcd(input longint x, input int n);
        logic [31:0] r = '0;
        longint      y = x;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    // Segments lit (active high, a..g from left) for each decimal digit
    function automatic logic [6:0] lit(input int d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b1111110; tbl[1] = 7'b0110000; tbl[2] = 7'b1101101;
        tbl[3] = 7'b1111001; tbl[4] = 7'b0110011; tbl[5] = 7'b1011011;
        tbl[6] = 7'b1011111; tbl[7] = 7'b1110000; tbl[8] = 7'b1111111;
        tbl[9] = 7'b1110011;
        return tbl[d];
    endfunction

    task automatic set_start(input int d, input logic v);
        start4 = (d == 0) ? v : 1'b0;
        start1 = (d == 1) ? v : 1'b0;
        start8 = (d == 2) ? v : 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        logic [55:0] zs;
        zs = '0;
        for (int i = 0; i < ndig(sel); i++) zs[7*i +: 7] = ~lit(0);
        check({tag, "_busy"}, 64'(cur_busy), 64'd0);
        check({tag, "_done"}, 64'(cur_done), 64'd0);
        check({tag, "_res"},  64'(cur_res),  64'd0);
        check({tag, "_sign"}, 64'(cur_sign), 64'd0);
        check({tag, "_ovf"},  64'(cur_ovf),  64'd0);
        check({tag, "_err"},  64'(cur_err),  64'd0);
        check({tag, "_seg"},  64'(cur_seg),  64'(zs));
    endtask

    task automatic run_op(input int d, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int          n, lat, cyc, busy_n;
        bit          bad;
        longint      av, bv, pw, s;
        logic [31:0] e_res;
        logic        e_sign, e_ovf;
        logic [55:0] e_seg;

        n  = ndig(d);
        pw = 1;
        for (int i = 0; i < n; i++) pw = pw * 10;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
        end
        e_sign = 1'b0;
        e_ovf  = 1'b0;
        if (bad) begin
            e_res = '0;
            lat   = 1;
        end else begin
            av = bcd2int(a, n);
            bv = bcd2int(b, n);
            if (!o) begin
                s     = av + bv;
                e_ovf = (s >= pw);
                e_res = int2bcd(s % pw, n);
                lat   = n + 1;
            end else begin
                s      = av - bv;
                e_sign = (s < 0);
                e_res  = int2bcd((s < 0) ? -s : s, n);
                lat    = (s < 0) ? 2 * n + 1 : n + 1;
            end
        end
        e_seg = '0;
        for (int i = 0; i < n; i++) e_seg[7*i +: 7] = bad ? 7'h7f : ~lit(int'(e_res[4*i +: 4]));

        sel = d;
        @(negedge clk);
        a_bus = a; b_bus = b; op = o;
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        a_bus = $urandom; b_bus = $urandom; op = 1'($urandom);
        cyc    = 1;
        busy_n = 0;
        if (lat > 1) check("hold_before_done", 64'(cur_res), 64'(prev_res[d]));
        while (!cur_done && cyc < 40) begin
            if (cur_busy) busy_n++;
            set_start(d, poke && cyc == 2);
            @(negedge clk);
            set_start(d, 1'b0);
            cyc++;
        end
        check("done_cycle", 64'(cyc),      64'(lat));
        check("busy_cycles", 64'(busy_n),  64'(lat - 1));
        check("result",     64'(cur_res),  64'(e_res));
        check("sign",       64'(cur_sign), 64'(e_sign));
        check("ovf",        64'(cur_ovf),  64'(e_ovf));
        check("err",        64'(cur_err),  64'(bad));
        check("seg",        64'(cur_seg),  64'(e_seg));
        @(negedge clk);
        check("done_pulse_len", 64'(cur_done), 64'd0);
        check("idle_after",     64'(cur_busy), 64'd0);
        check("result_held",    64'(cur_res),  64'(e_res));
        prev_res[d] = e_res;
    endtask

    function automatic logic [31:0] rand_bcd(input int n, input bit allow_bad);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 9) == 0) v[4*$urandom_range(0, n - 1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        int dn;
        rst_n = 1'b0;
        op = 1'b0; a_bus = '0; b_bus = '0;
        start4 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        sel = 0;
        for (int i = 0; i < 3; i++) prev_res[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        run_op(0, 1'b0, 32'h1234, 32'h5678, 1'b0);
        check("seg_digit3_six", 64'(cur_seg[27:21]), 64'b0100000);
        run_op(0, 1'b0, 32'h9999, 32'h0001, 1'b0);
        run_op(0, 1'b1, 32'h1000, 32'h0001, 1'b0);
        run_op(0, 1'b1, 32'h0500, 32'h0500, 1'b0);
        run_op(0, 1'b1, 32'h0001, 32'h1000, 1'b1);
        run_op(0, 1'b0, 32'h12A4, 32'h0000, 1'b0);
        run_op(0, 1'b0, 32'h0003, 32'h0004, 1'b1);

        // Reset in the middle of a subtract: no done, outputs back to reset values
        sel = 0;
        @(negedge clk);
        a_bus = 32'h0001; b_bus = 32'h1000; op = 1'b1;
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (cur_done) dn++;
        end
        check("no_done_after_abort", 64'(dn), 64'd0);
        for (int i = 0; i < 3; i++) prev_res[i] = '0;
        run_op(0, 1'b1, 32'h0001, 32'h1000, 1'b0);

        for (int d = 0; d < 3; d++) begin
            run_op(d, 1'b0, int2bcd(longint'(0), ndig(d)) | 32'h99999999 & int2bcd(longint'(99999999), ndig(d)), int2bcd(longint'(1), ndig(d)), 1'b0);
            for (int k = 0; k < 25; k++) begin
                run_op(d, 1'($urandom), rand_bcd(ndig(d), 1'b1), rand_bcd(ndig(d), 1'b1), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
